mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the adding machine's single 64x8 memory between two requesters.
- Port 0 is the CPU controller's fetch/execute bus. Port 1 is the program loader/debug port.
- Serialises accesses, drives the memory strobes and handles a ready-style memory acknowledge with timeout.
- Returns read data and a completion pulse to the winning requester.

Parameters:
- ADR_W, 6, memory address width (matches the 6-bit operand field).
- DATA_W, 8, memory word width.
- TIMEOUT, 15, cycles to wait for mem_ack before aborting; 0 = wait forever.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 request; held until gnt0.
- we0  in  1  port 0: 1 = write, 0 = read.
- adr0  in  ADR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- gnt0  out  1  port 0 grant, one-cycle pulse.
- done0  out  1  port 0 completion, one-cycle pulse.
- req1, we1, adr1, wdata1, gnt1, done1: same as port 0, for port 1.
- rdata  out  DATA_W  read data, valid when done0/done1 is high.
- err  out  1  timeout flag, valid with done0/done1.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_adr  out  ADR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  memory access complete.

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; timeout counter 0; last-owner pointer = 1. Asserting reset mid-access drops mem_rd/mem_wr immediately. No done is issued for the aborted transaction.
- States: IDLE, ACCESS, RESP (2-bit encoding).
- IDLE:
  - If req0 or req1 is sampled high, select a winner and capture its we/adr/wdata.
  - Set the owner, pulse gnt_owner for the next cycle, go to ACCESS.
  - If no request, stay in IDLE.
- ACCESS:
  - mem_adr = captured adr; mem_wdata = captured wdata.
  - mem_rd = !we; mem_wr = we; both held constant for the whole state.
  - On mem_ack=1: capture mem_rdata (reads only; writes return rdata=0), err=0, go to RESP.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT (TIMEOUT>0): err=1, rdata=0, go to RESP.
- RESP:
  - done_owner=1 for exactly one cycle; rdata and err valid in that cycle.
  - Strobes are 0. Next state IDLE; the counter clears.
- mem_ack is ignored in IDLE and RESP.
- Latency: req sampled at edge 0 gives gnt and strobe in cycle 1. If mem_ack is high in cycle 1, done is in cycle 2. Minimum three cycles per access; back-to-back accesses are one every 3 cycles.
- A request dropped before its grant is discarded. Requester inputs are ignored after the grant edge.
- Simultaneous requests: fixed priority, port 0 wins (CPU never stalls behind the loader unless it is already mid-access).
- gnt0/gnt1 are never high together; likewise done0/done1.
- rdata holds its last value outside done cycles; err clears to 0 on the next grant.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous req0 and req1, the port that was not the last owner wins. The last-owner pointer updates at every grant; reset value 1, so port 0 wins first. A single requester always wins regardless of the pointer.
- Undefined: strict port-0 priority as above; the pointer logic is not present.

Decomposition:
- Shared package (addmach_pkg): state encodings (ARB_IDLE=2'b00, ARB_ACCESS=2'b01, ARB_RESP=2'b10), ADR_W/DATA_W defaults, port index constants.
- One sub-module: arb_select. Combinational winner selection from req0, req1 and the last-owner pointer; contains the round-robin variant under the macro. The FSM and datapath stay in mem_arbiter.

Test Plan:
- Reset, then req0=1, we0=0, adr0=6'h05; memory returns 8'hA7 with ack on the first ACCESS cycle -> gnt0 cycle 1, mem_rd=1 with mem_adr=05 in cycle 1, done0=1 with rdata=A7, err=0 in cycle 2.
- req1 write adr1=6'h3F, wdata1=8'h5C, ack delayed 4 cycles -> mem_wr/mem_adr/mem_wdata stable for 4 cycles, done1 one cycle after ack, gnt0/done0 stay 0.
- req0 and req1 high together, repeated twice -> without macro: port 0, port 0. With MEM_ARB_ROUND_ROBIN_EN: port 0, then port 1.
- TIMEOUT=15, mem_ack never asserted -> strobe held 15 cycles, then done0=1, err=1, rdata=00; next access clears err.
- reset driven low in the middle of ACCESS -> mem_rd drops in the same cycle without waiting for a clock edge; no done pulse; first post-reset request is served normally.
- req1 pulsed for one cycle while port 0 is in ACCESS and dropped before grant -> no gnt1 and no port-1 memory strobe.

Source files
------------

// File: rtl/addmach_pkg.sv
// Shared definitions for the adding machine memory arbiter: state encodings,
// default bus widths and requester port indices.
package addmach_pkg;

    localparam int ADR_W_DEF  = 6;
    localparam int DATA_W_DEF = 8;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_ACCESS = 2'b01,
        ARB_RESP   = 2'b10
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory-side bus of the arbiter: strobes, address and data toward the 64x8
// memory, with the ready-style acknowledge coming back.
interface mem_arbiter_if #(
    parameter int ADR_W  = 6,
    parameter int DATA_W = 8
);
    logic              mem_rd;
    logic              mem_wr;
    logic [ADR_W-1:0]  mem_adr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_rd, mem_wr, mem_adr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_rd, mem_wr, mem_adr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_arbiter_arb_select.sv
// Combinational winner selection between the two requesters.
// MEM_ARB_ROUND_ROBIN_EN: alternate on contention instead of port-0 priority.
module arb_select
    import addmach_pkg::*;
(
    input  logic req0,
    input  logic req1,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic last_owner,
`endif
    output logic any_req,
    output logic winner
);

    always_comb begin
        any_req = req0 | req1;
        winner  = PORT0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (req0 && req1) begin
            winner = (last_owner == PORT0) ? PORT1 : PORT0;
        end else if (req1) begin
            winner = PORT1;
        end
`else
        if (!req0 && req1) begin
            winner = PORT1;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the adding machine's single memory, with ack timeout.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin contention handling.
module mem_arbiter
    import addmach_pkg::*;
#(
    parameter int ADR_W   = ADR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADR_W-1:0]  adr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              done0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADR_W-1:0]  adr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    mem_arbiter_if.master     mem
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              done0_q, done0_d, done1_q, done1_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
    logic [ADR_W-1:0]  mem_adr_q, mem_adr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              any_req, winner, finish;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_owner_q, last_owner_d;
`endif

    arb_select u_sel (
        .req0       (req0),
        .req1       (req1),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_owner (last_owner_q),
`endif
        .any_req    (any_req),
        .winner     (winner)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_adr_d   = mem_adr_q;
        mem_wdata_d = mem_wdata_q;
        finish      = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_owner_d = last_owner_q;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    state_d     = ARB_ACCESS;
                    owner_d     = winner;
                    gnt0_d      = (winner == PORT0);
                    gnt1_d      = (winner == PORT1);
                    err_d       = 1'b0;
                    cnt_d       = '0;
                    mem_wr_d    = (winner == PORT1) ? we1 : we0;
                    mem_rd_d    = (winner == PORT1) ? !we1 : !we0;
                    mem_adr_d   = (winner == PORT1) ? adr1 : adr0;
                    mem_wdata_d = (winner == PORT1) ? wdata1 : wdata0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_owner_d = winner;
`endif
                end
            end
            ARB_ACCESS: begin
                if (mem.mem_ack) begin
                    rdata_d = mem_wr_q ? '0 : mem.mem_rdata;
                    err_d   = 1'b0;
                    finish  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // cnt_q counts completed unacknowledged cycles, so the
                    // abort lands after exactly TIMEOUT strobe cycles.
                    if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        finish  = 1'b1;
                    end
                end
                if (finish) begin
                    state_d  = ARB_RESP;
                    done0_d  = (owner_q == PORT0);
                    done1_d  = (owner_q == PORT1);
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= PORT0;
            cnt_q       <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_adr_q   <= '0;
            mem_wdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_owner_q <= PORT1;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_adr_q   <= mem_adr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    assign gnt0          = gnt0_q;
    assign gnt1          = gnt1_q;
    assign done0         = done0_q;
    assign done1         = done1_q;
    assign rdata         = rdata_q;
    assign err           = err_q;
    assign mem.mem_rd    = mem_rd_q;
    assign mem.mem_wr    = mem_wr_q;
    assign mem.mem_adr   = mem_adr_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed test-plan steps followed by randomized
// transactions, checked against a transaction-level model with its own memory.
module tb_mem_arbiter;
    import addmach_pkg::*;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [5:0] adr0 = '0, adr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       gnt0, done0, gnt1, done1, err;
    logic [7:0] rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_model [64];
    int         last_owner;
    logic [7:0] last_rdata;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADR_W(6), .DATA_W(8)) mem ();

    mem_arbiter #(.ADR_W(6), .DATA_W(8), .TIMEOUT(TMO)) dut (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .we0    (we0),
        .adr0   (adr0),
        .wdata0 (wdata0),
        .gnt0   (gnt0),
        .done0  (done0),
        .req1   (req1),
        .we1    (we1),
        .adr1   (adr1),
        .wdata1 (wdata1),
        .gnt1   (gnt1),
        .done1  (done1),
        .rdata  (rdata),
        .err    (err),
        .mem    (mem)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return (last_owner == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        return r0 ? 0 : 1;
    endfunction

    // lat = ACCESS cycle in which mem_ack rises (1 = first); 0 or >TMO = never.
    task automatic access(input bit r0, input bit r1, input bit w0, input bit w1,
                          input logic [5:0] a0, input logic [5:0] a1,
                          input logic [7:0] d0, input logic [7:0] d1,
                          input int lat, input bit glitch1);
        int         win, n;
        bit         w, timeout;
        logic [5:0] a;
        logic [7:0] d, exp_rd;
        win     = pick(r0, r1);
        w       = (win == 1) ? w1 : w0;
        a       = (win == 1) ? a1 : a0;
        d       = (win == 1) ? d1 : d0;
        timeout = (lat == 0) || (lat > TMO);
        n       = timeout ? TMO : lat;
        req0 = r0; we0 = w0; adr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; adr1 = a1; wdata1 = d1;
        @(posedge clk); #1;
        last_owner = win;
        chk("gnt0", gnt0, win == 0);
        chk("gnt1", gnt1, win == 1);
        chk("err_cleared_at_gnt", err, 0);
        chk("rdata_held_at_gnt", rdata, last_rdata);
        chk("done0_at_gnt", done0, 0);
        chk("done1_at_gnt", done1, 0);
        req0 = 1'b0; req1 = 1'b0;
        we0 = ~we0; we1 = ~we1; adr0 = ~adr0; adr1 = ~adr1;
        wdata0 = 8'($urandom); wdata1 = 8'($urandom);
        for (int i = 1; i <= n; i++) begin
            if (i > 1) begin
                @(posedge clk); #1;
                chk("gnt0_in_access", gnt0, 0);
                chk("gnt1_in_access", gnt1, 0);
                chk("done_in_access", {done0, done1}, 0);
            end
            chk("mem_rd", mem.mem_rd, !w);
            chk("mem_wr", mem.mem_wr, w);
            chk("mem_adr", mem.mem_adr, a);
            chk("mem_wdata", mem.mem_wdata, d);
            if (glitch1 && i == 2) req1 = 1'b1;
            if (glitch1 && i == 3) req1 = 1'b0;
            mem.mem_rdata = 8'($urandom);
            if (!timeout && i == n) begin
                mem.mem_ack   = 1'b1;
                mem.mem_rdata = w ? 8'($urandom) : mem_model[a];
            end
        end
        @(posedge clk); #1;
        mem.mem_ack = 1'b0;
        exp_rd = (timeout || w) ? 8'h00 : mem_model[a];
        if (!timeout && w) mem_model[a] = d;
        chk("done0", done0, win == 0);
        chk("done1", done1, win == 1);
        chk("rdata", rdata, exp_rd);
        chk("err", err, timeout);
        chk("strobes_in_resp", {mem.mem_rd, mem.mem_wr}, 0);
        last_rdata = exp_rd;
        @(posedge clk); #1;
        chk("done_after_resp", {done0, done1}, 0);
        chk("gnt_after_resp", {gnt0, gnt1}, 0);
        chk("rdata_hold", rdata, last_rdata);
    endtask

    initial begin
        int         rr;
        int         lat;
        mem.mem_ack   = 1'b0;
        mem.mem_rdata = '0;
        for (int i = 0; i < 64; i++) mem_model[i] = 8'($urandom);
        mem_model[5] = 8'hA7;
        last_owner = 1;
        last_rdata = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {gnt0, gnt1, done0, done1, err, rdata}, 0);
        chk("reset_mem_bus", {mem.mem_rd, mem.mem_wr, mem.mem_adr, mem.mem_wdata}, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        access(1, 0, 0, 0, 6'h05, 6'h00, 8'h00, 8'h00, 1, 0);
        access(0, 1, 0, 1, 6'h00, 6'h3F, 8'h00, 8'h5C, 4, 0);
        access(1, 1, 0, 0, 6'h10, 6'h11, 8'h00, 8'h00, 2, 0);
        access(1, 1, 0, 0, 6'h12, 6'h3F, 8'h00, 8'h00, 2, 0);
        access(1, 0, 0, 0, 6'h07, 6'h00, 8'h00, 8'h00, 0, 0);
        access(1, 0, 1, 0, 6'h08, 6'h00, 8'h3C, 8'h00, 1, 0);
        access(1, 0, 0, 0, 6'h08, 6'h00, 8'h00, 8'h00, 5, 1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("no_gnt1_after_drop", gnt1, 0);
            chk("no_strobe_after_drop", {mem.mem_rd, mem.mem_wr}, 0);
        end

        req0 = 1'b1; we0 = 1'b0; adr0 = 6'h05;
        @(posedge clk); #1;
        req0 = 1'b0;
        chk("rst_pre_mem_rd", mem.mem_rd, 1);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("rst_async_mem_rd", mem.mem_rd, 0);
        chk("rst_async_gnt", {gnt0, gnt1}, 0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_no_done", {done0, done1}, 0);
        end
        chk("rst_rdata_err", {rdata, err}, 0);
        reset = 1'b1;
        last_owner = 1;
        last_rdata = 8'h00;
        access(1, 0, 0, 0, 6'h05, 6'h00, 8'h00, 8'h00, 1, 0);

        for (int t = 0; t < 40; t++) begin
            rr  = int'($urandom_range(1, 3));
            lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 5));
            access(rr[0], rr[1], 1'($urandom), 1'($urandom),
                   6'($urandom), 6'($urandom), 8'($urandom), 8'($urandom), lat, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
